// File: rtl/otbn_imem_arb_if.sv
// rtl/otbn_imem_arb_if.sv - fetch, host and IMEM port bundle for the OTBN IMEM arbiter
interface otbn_imem_arb_if #(
    parameter int ImemSizeByte = 4096
);
    localparam int ImemAddrWidth = (ImemSizeByte > 1) ? $clog2(ImemSizeByte) : 1;

    logic                     busy_i;

    logic                     fetch_req_i;
    logic [ImemAddrWidth-1:0] fetch_addr_i;
    logic                     fetch_gnt_o;
    logic                     fetch_rvalid_o;
    logic [31:0]              fetch_rdata_o;
    logic                     fetch_rerror_o;

    logic                     host_req_i;
    logic                     host_we_i;
    logic [ImemAddrWidth-1:0] host_addr_i;
    logic [31:0]              host_wdata_i;
    logic                     host_gnt_o;
    logic                     host_rvalid_o;
    logic [31:0]              host_rdata_o;
    logic                     host_rerror_o;

    logic                     imem_req_o;
    logic                     imem_we_o;
    logic [ImemAddrWidth-1:0] imem_addr_o;
    logic [31:0]              imem_wdata_o;
    logic [31:0]              imem_rdata_i;
    logic                     imem_rvalid_i;
    logic                     imem_rerror_i;

    logic                     fetch_err_o;
    logic [7:0]               host_blocked_cnt_o;

    modport slave (
        input  busy_i,
        input  fetch_req_i, fetch_addr_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_rerror_o,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_rerror_o,
        output imem_req_o, imem_we_o, imem_addr_o, imem_wdata_o,
        input  imem_rdata_i, imem_rvalid_i, imem_rerror_i,
        output fetch_err_o, host_blocked_cnt_o
    );

    modport master (
        output busy_i,
        output fetch_req_i, fetch_addr_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_rerror_o,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_rerror_o,
        input  imem_req_o, imem_we_o, imem_addr_o, imem_wdata_o,
        output imem_rdata_i, imem_rvalid_i, imem_rerror_i,
        input  fetch_err_o, host_blocked_cnt_o
    );
endinterface

// File: rtl/otbn_imem_arb.sv
// rtl/otbn_imem_arb.sv - shares the IMEM port between core fetch and host, routes responses by owner
module otbn_imem_arb #(
    parameter int ImemSizeByte = 4096
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    otbn_imem_arb_if.slave  bus
);
    localparam int ImemAddrWidth = (ImemSizeByte > 1) ? $clog2(ImemSizeByte) : 1;

    typedef enum logic [1:0] {
        OwnNone,
        OwnFetch,
        OwnHost,
        OwnBlocked
    } owner_e;

    owner_e                   owner_q, owner_d;
    logic                     busy_q;
    logic                     fetch_err_q;
    logic [7:0]               blk_cnt_q;
    logic                     fetch_to_imem, host_to_imem, host_refused;
    logic                     fetch_err_set, run_start;
    logic [ImemAddrWidth-1:0] addr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Grants and owner decode; busy gives fetch the port, idle gives it to the host.
    always_comb begin
        fetch_to_imem = bus.fetch_req_i & (bus.busy_i | ~bus.host_req_i);
        host_to_imem  = bus.host_req_i & ~bus.busy_i;
        host_refused  = bus.host_req_i & bus.busy_i;

        bus.fetch_gnt_o  = fetch_to_imem;
        bus.host_gnt_o   = bus.host_req_i;
        bus.imem_req_o   = fetch_to_imem | host_to_imem;
        bus.imem_we_o    = host_to_imem & bus.host_we_i;
        addr_d           = '0;
        bus.imem_wdata_o = '0;
        if (host_to_imem) begin
            addr_d           = bus.host_addr_i;
            bus.imem_wdata_o = bus.host_wdata_i;
        end else if (fetch_to_imem) begin
            addr_d = bus.fetch_addr_i;
        end
        bus.imem_addr_o = addr_d;

        owner_d = OwnNone;
        if (fetch_to_imem) begin
            owner_d = OwnFetch;
        end else if (host_to_imem) begin
            owner_d = OwnHost;
        end else if (host_refused) begin
            owner_d = OwnBlocked;
        end
    end

    // Routing keys off the registered owner, so a busy change after the grant cannot misroute.
    always_comb begin
        bus.fetch_rvalid_o = 1'b0;
        bus.fetch_rdata_o  = '0;
        bus.fetch_rerror_o = 1'b0;
        bus.host_rvalid_o  = 1'b0;
        bus.host_rdata_o   = '0;
        bus.host_rerror_o  = 1'b0;
        case (owner_q)
            OwnFetch: begin
                bus.fetch_rvalid_o = bus.imem_rvalid_i;
                bus.fetch_rdata_o  = bus.imem_rdata_i;
                bus.fetch_rerror_o = bus.imem_rvalid_i & bus.imem_rerror_i;
            end
            OwnHost: begin
                bus.host_rvalid_o = bus.imem_rvalid_i;
                bus.host_rdata_o  = bus.imem_rdata_i;
                bus.host_rerror_o = bus.imem_rvalid_i & bus.imem_rerror_i;
            end
            OwnBlocked: begin
                bus.host_rvalid_o = 1'b1;
                bus.host_rerror_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign fetch_err_set = (owner_q == OwnFetch) & bus.imem_rvalid_i & bus.imem_rerror_i;
    assign run_start     = bus.busy_i & ~busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            busy_q <= bus.busy_i;
            if (fetch_err_set) begin
                fetch_err_q <= 1'b1;
            end else if (run_start) begin
                fetch_err_q <= 1'b0;
            end
            if (run_start) begin
                blk_cnt_q <= '0;
            end else if (host_refused && blk_cnt_q != 8'hff) begin
                blk_cnt_q <= blk_cnt_q + 8'd1;
            end
        end
    end

    assign bus.fetch_err_o        = fetch_err_q;
    assign bus.host_blocked_cnt_o = blk_cnt_q;
endmodule

// File: tb/tb_otbn_imem_arb.sv
// tb/tb_otbn_imem_arb.sv - directed and random checks of otbn_imem_arb against a transaction-level model
module tb_otbn_imem_arb;
    localparam int W_NONE  = 0;
    localparam int W_FETCH = 1;
    localparam int W_HOST  = 2;
    localparam int W_BLK   = 3;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        err;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otbn_imem_arb_if #(.ImemSizeByte(4096)) bus();
    otbn_imem_arb #(.ImemSizeByte(4096)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int          n_tests = 0;
    int          n_fail = 0;
    item_t       pq[$];
    logic [31:0] mem[1024];
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    logic        m_prev_busy = 1'b0;
    logic        inj_err = 1'b0;
    logic        stray = 1'b0;
    logic [31:0] last_frd = '0;
    logic [31:0] last_hrd = '0;
    int          n_frv = 0;
    int          n_hrv = 0;
    int          hrv_before;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        item_t it;
        item_t nx;
        logic  f_mem, h_mem, h_blk, busy, rise, have_nx;
        logic [31:0] ex_addr;
        it = '{who: W_NONE, data: 32'h0, err: 1'b0};
        @(negedge clk);
        if (pq.size() > 0) it = pq.pop_front();
        if (!rst_n) it.who = W_NONE;
        busy  = bus.busy_i;
        f_mem = bus.fetch_req_i && (busy || !bus.host_req_i);
        h_mem = bus.host_req_i && !busy;
        h_blk = bus.host_req_i && busy;
        ex_addr = h_mem ? 32'(bus.host_addr_i) : (f_mem ? 32'(bus.fetch_addr_i) : 32'h0);
        chk("fetch_gnt", 32'(bus.fetch_gnt_o), 32'(f_mem));
        chk("host_gnt", 32'(bus.host_gnt_o), 32'(bus.host_req_i));
        chk("imem_req", 32'(bus.imem_req_o), 32'(f_mem || h_mem));
        chk("imem_we", 32'(bus.imem_we_o), 32'(h_mem && bus.host_we_i));
        chk("imem_addr", 32'(bus.imem_addr_o), ex_addr);
        chk("imem_wdata", bus.imem_wdata_o, h_mem ? bus.host_wdata_i : 32'h0);
        chk("fetch_rvalid", 32'(bus.fetch_rvalid_o), 32'(it.who == W_FETCH));
        chk("fetch_rdata", bus.fetch_rdata_o, (it.who == W_FETCH) ? it.data : 32'h0);
        chk("fetch_rerror", 32'(bus.fetch_rerror_o), 32'(it.who == W_FETCH && it.err));
        chk("host_rvalid", 32'(bus.host_rvalid_o), 32'(it.who == W_HOST || it.who == W_BLK));
        chk("host_rdata", bus.host_rdata_o, (it.who == W_HOST) ? it.data : 32'h0);
        chk("host_rerror", 32'(bus.host_rerror_o), 32'((it.who == W_HOST && it.err) || it.who == W_BLK));
        chk("fetch_err", 32'(bus.fetch_err_o), 32'(m_err));
        chk("blk_cnt", 32'(bus.host_blocked_cnt_o), 32'(m_cnt));
        if (bus.fetch_rvalid_o) begin last_frd = bus.fetch_rdata_o; n_frv++; end
        if (bus.host_rvalid_o) begin last_hrd = bus.host_rdata_o; n_hrv++; end
        have_nx = 1'b0;
        nx = '{who: W_NONE, data: 32'h0, err: 1'b0};
        @(posedge clk);
        if (!rst_n) begin
            pq.delete();
            m_err = 1'b0;
            m_cnt = 0;
            m_prev_busy = 1'b0;
        end else begin
            rise = busy && !m_prev_busy;
            if (it.who == W_FETCH && it.err) m_err = 1'b1;
            else if (rise) m_err = 1'b0;
            if (rise) m_cnt = 0;
            else if (h_blk && m_cnt < 255) m_cnt++;
            m_prev_busy = busy;
            if (f_mem) begin
                nx = '{who: W_FETCH, data: mem[bus.fetch_addr_i[11:2]], err: inj_err};
                have_nx = 1'b1;
            end else if (h_mem) begin
                if (bus.host_we_i) begin
                    nx = '{who: W_HOST, data: $urandom, err: inj_err};
                    mem[bus.host_addr_i[11:2]] = bus.host_wdata_i;
                end else begin
                    nx = '{who: W_HOST, data: mem[bus.host_addr_i[11:2]], err: inj_err};
                end
                have_nx = 1'b1;
            end else if (h_blk) begin
                nx = '{who: W_BLK, data: 32'h0, err: 1'b0};
            end
            if (nx.who != W_NONE) pq.push_back(nx);
        end
        #1;
        if (have_nx) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = nx.data;
            bus.imem_rerror_i = nx.err;
        end else begin
            bus.imem_rvalid_i = stray;
            bus.imem_rdata_i  = stray ? $urandom : 32'h0;
            bus.imem_rerror_i = stray ? 1'($urandom) : 1'b0;
        end
        inj_err = 1'b0;
        stray   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[4] = 32'hAAAA_0010;
        mem[5] = 32'hBBBB_0014;
        bus.busy_i = 1'b0;
        bus.fetch_req_i = 1'b0; bus.fetch_addr_i = '0;
        bus.host_req_i = 1'b0; bus.host_we_i = 1'b0; bus.host_addr_i = '0; bus.host_wdata_i = '0;
        bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.imem_rerror_i = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset_cnt", 32'(bus.host_blocked_cnt_o), 32'h0);
        chk("reset_err", 32'(bus.fetch_err_o), 32'h0);

        // run fetch
        bus.busy_i = 1'b1;
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 12'h010; tick();
        chk("run_fetch_cnt_a", 32'(n_frv), 32'h0);
        bus.fetch_addr_i = 12'h014; tick();
        chk("run_fetch_data_a", last_frd, 32'hAAAA_0010);
        bus.fetch_req_i = 1'b0; tick();
        chk("run_fetch_data_b", last_frd, 32'hBBBB_0014);
        chk("run_fetch_host_quiet", 32'(n_hrv), 32'h0);

        // blocked host write beside a fetch
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 12'h020;
        bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 12'h040; bus.host_wdata_i = 32'hDEAD_BEEF;
        tick();
        bus.fetch_req_i = 1'b0; bus.host_req_i = 1'b0; tick();
        chk("blocked_cnt_one", 32'(bus.host_blocked_cnt_o), 32'h1);
        chk("blocked_rdata", last_hrd, 32'h0);

        // idle contention: host first, then fetch
        bus.busy_i = 1'b0;
        bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 12'h040;
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 12'h030;
        tick();
        bus.host_req_i = 1'b0; tick();
        chk("contention_host_data", last_hrd, mem[16]);
        bus.fetch_req_i = 1'b0; tick();
        chk("contention_fetch_data", last_frd, mem[12]);

        // busy falls right after a fetch grant
        bus.busy_i = 1'b1; bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 12'h050; tick();
        hrv_before = n_hrv;
        bus.busy_i = 1'b0; bus.fetch_req_i = 1'b0; tick();
        chk("busy_fall_fetch_data", last_frd, mem[20]);
        chk("busy_fall_host_quiet", 32'(n_hrv), 32'(hrv_before));

        // error set coincides with run start: set wins
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 12'h058; inj_err = 1'b1; tick();
        bus.busy_i = 1'b1; bus.fetch_req_i = 1'b0; tick();
        chk("err_set_beats_clear", 32'(bus.fetch_err_o), 32'h1);

        // ECC error plus 300 blocked host accesses
        bus.busy_i = 1'b0; tick();
        bus.busy_i = 1'b1; bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 12'h060; inj_err = 1'b1;
        bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 12'h064;
        tick();
        bus.fetch_req_i = 1'b0;
        for (int i = 0; i < 299; i++) tick();
        chk("blk_cnt_saturated", 32'(bus.host_blocked_cnt_o), 32'd255);
        chk("ecc_err_flag", 32'(bus.fetch_err_o), 32'h1);
        bus.busy_i = 1'b0; bus.host_req_i = 1'b0; tick(); tick();
        chk("ecc_err_held_idle", 32'(bus.fetch_err_o), 32'h1);
        chk("blk_cnt_held_idle", 32'(bus.host_blocked_cnt_o), 32'd255);
        bus.busy_i = 1'b1; bus.host_req_i = 1'b1; tick();
        chk("run_clear_err", 32'(bus.fetch_err_o), 32'h0);
        chk("run_clear_cnt", 32'(bus.host_blocked_cnt_o), 32'h0);
        bus.host_req_i = 1'b0; tick();

        // reset in the cycle after a host read grant
        bus.busy_i = 1'b0;
        bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 12'h070; tick();
        hrv_before = n_hrv;
        bus.host_req_i = 1'b0; rst_n = 1'b0; tick();
        stray = 1'b1; tick();
        rst_n = 1'b1; tick();
        chk("reset_drop_host", 32'(n_hrv), 32'(hrv_before));
        tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.busy_i = ~bus.busy_i;
            bus.fetch_req_i  = 1'($urandom);
            bus.fetch_addr_i = 12'($urandom);
            bus.host_req_i   = ($urandom_range(0, 2) == 0);
            bus.host_we_i    = 1'($urandom);
            bus.host_addr_i  = 12'($urandom);
            bus.host_wdata_i = $urandom;
            inj_err = ($urandom_range(0, 7) == 0);
            stray   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
